l1_word_cache: RTL and testbench
================================

L1_WORD_CACHE -- requirements
Module: l1_word_cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of one-word lines (power of 2, >=2); IDX=log2(NUM_LINES).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port read  input  1  CPU read request, held until resp.
REQ-005 SHALL have port write  input  1  CPU write request, held until resp.
REQ-006 SHALL have port wmask  input  4  CPU byte-write enables, bit i = byte i.
REQ-007 SHALL have port address  input  32  CPU byte address; bits [1:0] ignored.
REQ-008 SHALL have port wdata  input  32  CPU write data.
REQ-009 SHALL have port resp  output  1  one-cycle completion of the current CPU request.
REQ-010 SHALL have port rdata  output  32  read data, valid when resp=1 for a read.
REQ-011 SHALL have ports hit, miss  output  1 each  one-cycle performance pulses.
REQ-012 SHALL have ports mem_read, mem_write  output  1 each  lower-level request strobes.
REQ-013 SHALL have ports mem_wmask  output  4, mem_address  output  32, mem_wdata  output  32.
REQ-014 SHALL have ports mem_resp  input  1, mem_rdata  input  32  lower-level completion and data.

Function
REQ-015 SHALL decompose address: index=address[IDX+1:2], tag=address[31:IDX+2]; each line holds valid, tag, 32-bit data.
REQ-016 SHALL implement FSM states IDLE, FETCH, WRITE_THRU.
REQ-017 SHALL treat read=1 and write=1 together as a write.
REQ-018 IDLE, read, valid tag match: resp=1 and rdata=line data combinationally in the same cycle, hit=1, state stays IDLE (zero-cycle hit).
REQ-019 IDLE, read, mismatch or invalid: resp=0, miss=1 for that one cycle, latch word address, go to FETCH.
REQ-020 FETCH: mem_read=1, mem_address={latched[31:2],2'b00}; on mem_resp: resp=1, rdata=mem_rdata (same cycle), install line (valid=1, tag, data) at that edge, go IDLE.
REQ-021 IDLE, write: resp=0, hit=1 if tag matches valid line else miss=1, latch address/wdata/wmask/hit-flag, go to WRITE_THRU.
REQ-022 WRITE_THRU: mem_write=1 with latched word address, wdata, wmask; on mem_resp: resp=1, go IDLE; if latched hit-flag, merge only wmask-enabled bytes into the line at that edge; no allocation on write miss.
REQ-023 SHALL hold mem_* strobes asserted and constant every cycle until mem_resp; mem_read and mem_write never both 1.
REQ-024 SHALL ignore mem_resp in IDLE; in IDLE mem_read=mem_write=0.
REQ-025 IDLE, read=write=0: resp=hit=miss=0, no state change.
REQ-026 hit and miss SHALL never both be 1 and SHALL pulse exactly once per accepted request.
REQ-027 CPU inputs SHALL be don't-care outside IDLE; all outgoing values come from latched copies.
REQ-028 rdata SHALL equal indexed line data whenever resp=0 in IDLE (deterministic, no X).
REQ-029 After resp, next request SHALL be accepted the following cycle with no idle bubble.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, all valid bits 0, resp=hit=miss=mem_read=mem_write=0.
REQ-031 Reset mid-FETCH/WRITE_THRU SHALL abandon the transaction, install nothing, and not assert resp.
REQ-032 Tag/data arrays need no reset; first access to any address after reset (including 0x0) SHALL miss.

Verification
REQ-033 After reset, read 0x0000_0040, mem_rdata=0xDEAD_BEEF after 3 cycles -> miss pulse, mem_read 3 cycles, resp with rdata 0xDEAD_BEEF; reread -> same-cycle resp, hit, no mem_read.
REQ-034 Line at 0x40 = 0x1122_3344; write 0x40, wmask=4'b0010, wdata=0x0000_AA00 -> hit, mem_write with same mask; later read 0x40 -> 0x1122_AA44, hit.
REQ-035 Write miss 0x80, then read 0x80 -> write-through only, no install; read misses.
REQ-036 NUM_LINES=8: read 0x40 then 0x60 (same index, tags differ) -> both miss; 0x40 again misses (evicted).
REQ-037 Assert rst_n=0 during FETCH with mem_resp pending -> strobes drop asynchronously; following read to same address misses.
REQ-038 read=write=1 at 0x40 -> handled as write: mem_write=1, mem_read=0.

Source files
------------

// File: rtl/l1_word_cache.sv
// l1_word_cache: direct-mapped, one-word-per-line, write-through /
// no-write-allocate L1 cache between a CPU port and a lower memory level.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   read, write, wmask,          CPU request (held until resp); read+write
//   address, wdata               together is treated as a write
//   resp, rdata                  one-cycle completion, read data
//   hit, miss                    one-cycle performance pulses per request
//   mem_read, mem_write,         lower-level request, held constant
//   mem_wmask, mem_address,      until mem_resp
//   mem_wdata
//   mem_resp, mem_rdata          lower-level completion and read data
module l1_word_cache #(
    parameter int NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  wmask,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        resp,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        miss,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE_THRU} state_t;
    state_t state, state_nxt;

    logic [NUM_LINES-1:0]           valid_q;
    logic [NUM_LINES-1:0][TAGW-1:0] tag_q;
    logic [NUM_LINES-1:0][31:0]     data_q;

    // Latched request: everything driven outside IDLE comes from these.
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        hit_q;

    logic [IDX-1:0]  cpu_idx, lat_idx;
    logic [TAGW-1:0] cpu_tag, lat_tag;
    logic            lookup_hit, fill_en, merge_en;
    logic            unused_addr_lsb;

    assign cpu_idx         = address[IDX+1:2];
    assign cpu_tag         = address[31:IDX+2];
    assign lat_idx         = addr_q[IDX-1:0];
    assign lat_tag         = addr_q[29:IDX];
    assign unused_addr_lsb = ^address[1:0];
    assign lookup_hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    assign mem_address = {addr_q, 2'b00};
    assign mem_wdata   = wdata_q;
    assign mem_wmask   = wmask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        resp      = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        fill_en   = 1'b0;
        merge_en  = 1'b0;
        rdata     = data_q[cpu_idx];
        unique case (state)
            IDLE: begin
                // rst_n gating keeps the pulses low while reset is held
                if (rst_n && write) begin
                    hit       = lookup_hit;
                    miss      = !lookup_hit;
                    state_nxt = WRITE_THRU;
                end else if (rst_n && read) begin
                    if (lookup_hit) begin
                        resp = 1'b1;
                        hit  = 1'b1;
                    end else begin
                        miss      = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                rdata    = data_q[lat_idx];
                if (mem_resp) begin
                    resp      = 1'b1;
                    rdata     = mem_rdata;
                    fill_en   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE_THRU: begin
                mem_write = 1'b1;
                rdata     = data_q[lat_idx];
                if (mem_resp) begin
                    resp      = 1'b1;
                    merge_en  = hit_q;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arrays are cleared on reset too so rdata is never X before a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt != IDLE) begin
                addr_q  <= address[31:2];
                wdata_q <= wdata;
                wmask_q <= wmask;
                hit_q   <= lookup_hit;
            end
            if (fill_en) begin
                valid_q[lat_idx] <= 1'b1;
                tag_q[lat_idx]   <= lat_tag;
                data_q[lat_idx]  <= mem_rdata;
            end
            // Write hit: only the enabled bytes of the resident line change.
            if (merge_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask_q[b]) data_q[lat_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_word_cache.sv
module tb_l1_word_cache;
    logic        clk = 1'b0, rst_n = 1'b0, read = 1'b0, write = 1'b0;
    logic [3:0]  wmask = '0;
    logic [31:0] address = '0, wdata = '0;
    logic        resp, hit, miss, mem_read, mem_write;
    logic [31:0] rdata, mem_address, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;

    l1_word_cache #(.NUM_LINES(8)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .wmask(wmask),
        .address(address), .wdata(wdata), .resp(resp), .rdata(rdata),
        .hit(hit), .miss(miss), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic is_rd; logic [31:0] data;} resp_t;
    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data; logic [3:0] mask;} memop_t;

    resp_t  resp_q[$];
    logic   perf_q[$];
    memop_t mem_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int n_vec = 0, n_err = 0, rd_cyc = 0, mem_lat = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Lower-level memory: answers after mem_lat strobe cycles.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_resp || !rst_n) begin
                mem_resp = 1'b0;
                cnt = 0;
            end
            if (rst_n && mem_read) rd_cyc++;
            if (rst_n && (mem_read || mem_write)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_model.exists(mem_address) ? mem_model[mem_address] : 32'h0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    resp_t  mon_r;
    memop_t mon_m;
    logic   mon_h;
    always @(negedge clk) begin
        if (resp) begin
            if (resp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_resp: got resp=1, want no response");
            end else begin
                mon_r = resp_q.pop_front();
                if (mon_r.is_rd) chk("rdata", rdata, mon_r.data);
                else             chk("wr_resp_mem_write", {31'b0, mem_write}, 32'd1);
            end
        end
        if (hit || miss) begin
            if (perf_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_perf: got hit=%0b miss=%0b, want none", hit, miss);
            end else begin
                mon_h = perf_q.pop_front();
                chk("hit_miss", {30'b0, hit, miss}, {30'b0, mon_h, ~mon_h});
            end
        end
        if (mem_resp && (mem_read || mem_write)) begin
            if (mem_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_mem_op: got rd=%0b wr=%0b, want none", mem_read, mem_write);
            end else begin
                mon_m = mem_q.pop_front();
                chk("mem_rd_wr", {30'b0, mem_write, mem_read}, {30'b0, mon_m.wr, ~mon_m.wr});
                chk("mem_address", mem_address, mon_m.addr);
                if (mon_m.wr) begin
                    chk("mem_wdata", mem_wdata, mon_m.data);
                    chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, mon_m.mask});
                end
            end
        end
    end

    // Issue one CPU request and hold it until resp; returns at that negedge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m,
                       input logic exp_hit, input logic [31:0] exp_rd);
        memop_t op;
        resp_t  r;
        logic   got;
        @(posedge clk); #1;
        perf_q.push_back(exp_hit);
        op.wr = wr; op.addr = {a[31:2], 2'b00}; op.data = wd; op.mask = m;
        if (wr || !exp_hit) mem_q.push_back(op);
        r.is_rd = rd && !wr; r.data = exp_rd;
        resp_q.push_back(r);
        read = rd; write = wr; address = a; wdata = wd; wmask = m;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = resp;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout: got no resp at 0x%08h, want resp within 50 cycles", a);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    int c0;
    initial begin
        mem_model[32'h0]  = 32'h0BAD_F00D;
        mem_model[32'h40] = 32'hDEAD_BEEF;
        mem_model[32'h60] = 32'h6060_6060;
        mem_model[32'h80] = 32'hCAFE_F00D;
        mem_model[32'h24] = 32'hA5A5_5A5A;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'b0, resp, hit, miss, mem_read, mem_write}, 32'h0);
        #2 rst_n = 1'b1;

        req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D);         // 0x0 misses after reset
        c0 = rd_cyc;
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        chk("fetch_rd_cycles", rd_cyc - c0, 32'd3);
        c0 = rd_cyc;
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);        // zero-cycle hit
        chk("hit_rd_cycles", rd_cyc - c0, 32'd0);

        mem_model[32'h40] = 32'h1122_3344;
        req(1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 1'b0, 32'h6060_6060);        // conflict evicts 0x40
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h1122_3344);
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1122_3344);

        req(1'b0, 1'b1, 32'h40, 32'h0000_AA00, 4'b0010, 1'b1, 32'h0);     // write hit, byte merge
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1122_AA44);

        req(1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'hF, 1'b0, 32'h0);        // write miss, no allocate
        req(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D);
        req(1'b1, 1'b1, 32'h40, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0);        // read+write = write
        req(1'b1, 1'b0, 32'h83, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);        // low bits ignored
        idle();

        // Reset during FETCH: strobes drop at once, nothing installed.
        @(posedge clk); #1;
        perf_q.push_back(1'b0);
        read = 1'b1; write = 1'b0; address = 32'h24;
        repeat (3) @(negedge clk);
        chk("fetch_in_progress", {31'b0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_fetch", {27'b0, resp, hit, miss, mem_read, mem_write}, 32'h0);
        @(posedge clk); #1 read = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;

        req(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'hA5A5_5A5A);
        req(1'b1, 1'b0, 32'h83, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D);        // valid bits cleared
        req(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 32'hA5A5_5A5A);
        idle();

        repeat (5) @(negedge clk);
        chk("pending_resp", resp_q.size(), 32'd0);
        chk("pending_perf", perf_q.size(), 32'd0);
        chk("pending_mem",  mem_q.size(),  32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
